// File: rtl/axi4_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : axi4_ram_bridge
// Description : AXI4 slave that serves one burst at a time and turns every
//               beat into a single access on a flat, word-indexed RAM port.
//               Reads and writes are arbitrated round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_ram_bridge #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned ID_W     = 4,
    parameter logic [31:0] RAM_BASE = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    // read address channel
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [ID_W-1:0]   arid,
    input  logic [7:0]        arlen,
    input  logic [1:0]        arburst,
    // read data channel
    output logic              rvalid,
    input  logic              rready,
    output logic [31:0]       rdata,
    output logic [ID_W-1:0]   rid,
    output logic [1:0]        rresp,
    output logic              rlast,
    // write address channel
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [ID_W-1:0]   awid,
    input  logic [7:0]        awlen,
    input  logic [1:0]        awburst,
    // write data channel
    input  logic              wvalid,
    output logic              wready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    // write response channel
    output logic              bvalid,
    input  logic              bready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    // RAM helper port
    output logic [31:0]       ram_ridx,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       ram_widx,
    output logic [31:0]       ram_wdata,
    output logic [31:0]       ram_wmask,
    output logic              ram_wen
);

    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_WRESP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            last_wr_q, last_wr_d;   // 1: the last granted channel was write
    logic [31:0]     ridx_q, ridx_d;         // read index, also drives ram_ridx
    logic [31:0]     widx_q, widx_d;         // write index of the next W beat
    logic            fixed_q, fixed_d;       // FIXED burst: index never advances
    logic [7:0]      len_q, len_d;
    logic [7:0]      beat_q, beat_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            err_q, err_d;           // sticky wlast/beat-count mismatch
    logic            beat_rdy_q, beat_rdy_d; // RAM data for ridx_q is now valid

    logic [31:0]     w_ar_off, w_aw_off;
    logic [31:0]     w_ar_idx, w_aw_idx;
    logic            w_grant_rd, w_grant_wr;
    logic            w_last_beat;
    logic [31:0]     w_step;

    // Word index relative to the RAM base; wraps modulo 2^32, low bits dropped.
    assign w_ar_off = 32'(araddr) - RAM_BASE;
    assign w_aw_off = 32'(awaddr) - RAM_BASE;
    assign w_ar_idx = w_ar_off >> 2;
    assign w_aw_idx = w_aw_off >> 2;

    // Round-robin: on a tie the channel not served last wins.
    assign w_grant_rd  = arvalid && (!awvalid || last_wr_q);
    assign w_grant_wr  = awvalid && (!arvalid || !last_wr_q);
    assign w_last_beat = (beat_q == len_q);
    assign w_step      = fixed_q ? 32'd0 : 32'd1;

    // Fields that are pure functions of latched state or pass-through data.
    assign rdata     = ram_rdata;
    assign rid       = id_q;
    assign rresp     = c_RESP_OKAY;
    assign rlast     = rvalid && w_last_beat;
    assign bid       = id_q;
    assign bresp     = err_q ? c_RESP_SLVERR : c_RESP_OKAY;
    assign ram_ridx  = ridx_q;
    assign ram_widx  = widx_q;
    assign ram_wdata = wdata;

    // Byte strobes expanded to a full bit mask for the helper.
    for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
        assign ram_wmask[gi*8 +: 8] = {8{wstrb[gi]}};
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        last_wr_d  = last_wr_q;
        ridx_d     = ridx_q;
        widx_d     = widx_q;
        fixed_d    = fixed_q;
        len_d      = len_q;
        beat_d     = beat_q;
        id_d       = id_q;
        err_d      = err_q;
        beat_rdy_d = beat_rdy_q;
        arready    = 1'b0;
        awready    = 1'b0;
        rvalid     = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        ram_wen    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_grant_rd) begin
                    arready    = 1'b1;
                    state_d    = ST_READ;
                    last_wr_d  = 1'b0;
                    ridx_d     = w_ar_idx;
                    fixed_d    = (arburst == c_BURST_FIXED);
                    len_d      = arlen;
                    beat_d     = 8'd0;
                    id_d       = arid;
                    beat_rdy_d = 1'b0;
                end else if (w_grant_wr) begin
                    awready    = 1'b1;
                    state_d    = ST_WRITE;
                    last_wr_d  = 1'b1;
                    widx_d     = w_aw_idx;
                    fixed_d    = (awburst == c_BURST_FIXED);
                    len_d      = awlen;
                    beat_d     = 8'd0;
                    id_d       = awid;
                    err_d      = 1'b0;
                end
            end
            ST_READ: begin
                rvalid = beat_rdy_q;
                if (beat_rdy_q && rready) begin
                    beat_rdy_d = 1'b0;
                    if (w_last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                        ridx_d = ridx_q + w_step;
                    end
                end else begin
                    // Index has been stable for a full cycle: RAM data is valid next.
                    beat_rdy_d = 1'b1;
                end
            end
            ST_WRITE: begin
                wready = 1'b1;
                if (wvalid) begin
                    // Gated by rst_n so an abandoned burst never writes in the reset cycle.
                    ram_wen = rst_n;
                    if (wlast != w_last_beat) begin
                        err_d = 1'b1;
                    end
                    if (w_last_beat) begin
                        state_d = ST_WRESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                        widx_d = widx_q + w_step;
                    end
                end
            end
            ST_WRESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and burst-context registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_wr_q  <= 1'b1;
            ridx_q     <= 32'd0;
            widx_q     <= 32'd0;
            fixed_q    <= 1'b0;
            len_q      <= 8'd0;
            beat_q     <= 8'd0;
            id_q       <= '0;
            err_q      <= 1'b0;
            beat_rdy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_wr_q  <= last_wr_d;
            ridx_q     <= ridx_d;
            widx_q     <= widx_d;
            fixed_q    <= fixed_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            id_q       <= id_d;
            err_q      <= err_d;
            beat_rdy_q <= beat_rdy_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/axi4_ram_bridge.md
# axi4_ram_bridge

AXI4 slave that fronts the DPI-backed simulation RAM helper (word-indexed read/write port, one call per clock) and turns AXI4 read and write bursts into per-beat helper accesses. It sits between the SoC memory crossbar in the simulation top and the RAM helper instance. It lets the DUT's memory port talk standard AXI4 while the helper keeps its flat 32-bit index interface. The bridge serves one transaction at a time; reads and writes are arbitrated round-robin.

## Interface
Parameters:
- `ADDR_W`, 32: AXI address width.
- `ID_W`, 4: AXI ID width.
- `RAM_BASE`, 32'h8000_0000: byte address mapped to helper index 0.

Ports:
- `clk` in 1: single clock. All logic runs on the rising edge.
- `rst_n` in 1: reset. Synchronous, active-low.
- `arvalid` in 1, `arready` out 1, `araddr` in ADDR_W, `arid` in ID_W, `arlen` in 8, `arburst` in 2: read address channel.
- `rvalid` out 1, `rready` in 1, `rdata` out 32, `rid` out ID_W, `rresp` out 2, `rlast` out 1: read data channel.
- `awvalid` in 1, `awready` out 1, `awaddr` in ADDR_W, `awid` in ID_W, `awlen` in 8, `awburst` in 2: write address channel.
- `wvalid` in 1, `wready` out 1, `wdata` in 32, `wstrb` in 4, `wlast` in 1: write data channel.
- `bvalid` out 1, `bready` in 1, `bid` out ID_W, `bresp` out 2: write response channel.
- `ram_ridx` out 32: helper read index.
- `ram_rdata` in 32: helper read data. Reflects the `ram_ridx` sampled at the previous edge.
- `ram_widx` out 32, `ram_wdata` out 32: helper write index and write data.
- `ram_wmask` out 32: helper byte-expanded write mask.
- `ram_wen` out 1: helper write enable.

## Operation
- States: IDLE, READ, WRITE, WRESP.
- IDLE, request arbitration:
  - If only `arvalid` is high, `arready`=1. If only `awvalid` is high, `awready`=1.
  - If both are high, grant the channel not served last. The last-served flag resets to "write", so read wins first.
  - Readies are 0 in every other state.
- Index computation: index = (addr − RAM_BASE) >> 2, taken modulo 2^32. Low two address bits are ignored. Size is always 4 bytes per beat.
- Burst types:
  - FIXED (2'b00): index is held for the whole burst.
  - INCR (2'b01) and WRAP (2'b10): index += 1 per beat. WRAP is treated as INCR.
- Beat count: arlen/awlen + 1, i.e. 1–256 beats. A beat counter compares against len.
- READ:
  - `ram_ridx` = current index, held constant while a beat is pending.
  - `beat_rdy` flag: cleared on entry and after each R handshake; set one cycle after the index is stable.
  - Data channel: `rvalid` = `beat_rdy`; `rdata` = `ram_rdata` combinationally.
  - Response fields: `rid` = latched arid; `rresp` = 2'b00; `rlast` = 1 on the final beat.
  - On an R handshake of the last beat, go to IDLE.
- WRITE:
  - `wready` = 1.
  - On each W handshake: `ram_wen` = 1 (combinational), `ram_widx` = current index, `ram_wdata` = `wdata`.
  - `ram_wmask` is `wstrb` expanded per byte (bit i → byte i = 8'hFF).
  - If `wlast` disagrees with the final-beat count on any beat, set a sticky error.
  - The burst ends on the counted final beat, not on `wlast`; then go to WRESP.
- WRESP:
  - `bvalid` = 1, `bid` = latched awid.
  - `bresp` = 2'b10 (SLVERR) if the error flag is set, else 2'b00.
  - On `bready`, go to IDLE and clear the error flag.
- `ram_wen` is 0 in every cycle without a W handshake. `ram_ridx` holds its last value outside READ.

## Timing
- Reset values: state IDLE; all readies and valids 0; `ram_wen` 0; `ram_ridx` 0; last-served = write; error flag 0.
- Reset during a burst abandons it: IDLE the next cycle, no further `ram_wen`, no R or B beat emitted.
- Read latency: AR handshake at cycle 0 → `ram_ridx` driven at cycle 1 → `rvalid` at cycle 2.
- Read throughput: after an R handshake at cycle n, `rvalid` is 0 at n+1 and 1 at n+2, so peak is 1 beat per 2 cycles.
- `rvalid` stays high with stable `rdata` and `rid` until `rready`; the index does not advance under backpressure.
- Write: AW handshake at cycle 0 → `wready` from cycle 1 → one helper write per W handshake, in the same cycle. After the final beat at cycle k, `bvalid` at k+1.
- Turnaround: the earliest next AR/AW acceptance is the cycle after the final R or B handshake.

## Test plan
- Single read: preload index 0 = 32'hDEAD_BEEF; AR at 32'h8000_0000, len 0 → `rvalid` at cycle 2 with `rdata` DEAD_BEEF, `rlast`=1, `rresp`=0.
- INCR read, 4 beats, `rready` toggled 1/0: araddr 32'h8000_0010 → indices 4, 5, 6, 7 in order; `rdata` stable while stalled; `rlast` on beat 4 only.
- Write, 2 beats, `wstrb` 4'b0101 then 4'b1111, awaddr 32'h8000_0008 → `ram_wen` pulses with idx 2 / mask 32'h00FF00FF, then idx 3 / mask 32'hFFFFFFFF; `bresp`=0.
- Simultaneous AR and AW three times → granted order read, write, read.
- Write len 1 with `wlast`=1 on beat 1 → 2 helper writes occur, then `bresp`=2'b10; the next write returns 2'b00.
- `rst_n` low for one cycle mid 8-beat write after beat 3 → no further `ram_wen`, no `bvalid`; a new AR is accepted after reset.
